// File: rtl/tow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tow_pkg
// Description : Shared types and default sizing for the tug-of-war playfield.
// Revision    : 1.0 - initial release
// ============================================================================
package tow_pkg;

  // Playfield round state
  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } tow_state_t;

  // Default playfield width (odd, >= 3) and blank hold-off after a win (>= 1)
  localparam int DEF_NUM_LIGHTS  = 9;
  localparam int DEF_HOLD_CYCLES = 4;

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Post-win hold-off down-counter. Loaded with HOLD_CYCLES on a
//               win; done marks the last hold cycle so the playfield leaves
//               HOLD on the following edge.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] C_LOAD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0] r_count;

  // Load on win, then count down to zero and stay there
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= C_LOAD;
    end else if (r_count != '0) begin
      r_count <= r_count - C_ONE;
    end
  end

  // Count of one means the current cycle is the last blank cycle
  assign done = (r_count == C_ONE);

endmodule
`default_nettype wire

// File: rtl/tow_playfield.sv
`default_nettype none
// ============================================================================
// Module      : tow_playfield
// Description : Tug-of-war playfield controller. Moves a one-hot rope light
//               one step per qualified press, pulses left_win/right_win (which
//               feed the score counters' incr inputs) when the rope is pulled
//               off an end, blanks the field for HOLD_CYCLES and then restarts
//               at centre, or parks blank in DONE when frozen.
// Revision    : 1.0 - initial release
// ============================================================================
module tow_playfield
  import tow_pkg::*;
#(
  parameter int NUM_LIGHTS  = DEF_NUM_LIGHTS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  L_press,
  input  logic                  R_press,
  input  logic                  freeze,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  left_win,
  output logic                  right_win,
  output logic                  playing
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam logic [PW-1:0]         C_CENTRE   = PW'(NUM_LIGHTS / 2);
  localparam logic [PW-1:0]         C_LEFT_POS = PW'(NUM_LIGHTS - 1);
  localparam logic [PW-1:0]         C_POS_ONE  = PW'(1);
  localparam logic [NUM_LIGHTS-1:0] C_LIGHT1   = NUM_LIGHTS'(1);

  tow_state_t       r_state;
  logic [PW-1:0]    r_pos;

  logic             w_l_only;
  logic             w_r_only;
  logic             w_left_win;
  logic             w_right_win;
  logic             w_win;
  logic             w_hold_done;
  logic [PW-1:0]    w_pos_inc;
  logic [PW-1:0]    w_pos_dec;

  // Simultaneous presses cancel; only a lone press counts
  assign w_l_only    = L_press & ~R_press;
  assign w_r_only    = R_press & ~L_press;
  assign w_left_win  = (r_state == PLAY) && w_l_only && (r_pos == C_LEFT_POS);
  assign w_right_win = (r_state == PLAY) && w_r_only && (r_pos == '0);
  assign w_win       = w_left_win | w_right_win;
  assign w_pos_inc   = r_pos + C_POS_ONE;
  assign w_pos_dec   = r_pos - C_POS_ONE;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .Reset (Reset),
    .load  (w_win),
    .done  (w_hold_done)
  );

  // Round state machine with registered lights, win pulses and playing flag
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state   <= PLAY;
      r_pos     <= C_CENTRE;
      lights    <= C_LIGHT1 << C_CENTRE;
      playing   <= 1'b1;
      left_win  <= 1'b0;
      right_win <= 1'b0;
    end else begin
      left_win  <= 1'b0;
      right_win <= 1'b0;
      unique case (r_state)
        PLAY: begin
          if (w_win) begin
            left_win  <= w_left_win;
            right_win <= w_right_win;
            lights    <= '0;
            playing   <= 1'b0;
            r_state   <= HOLD;
          end else if (w_l_only) begin
            r_pos  <= w_pos_inc;
            lights <= C_LIGHT1 << w_pos_inc;
          end else if (w_r_only) begin
            r_pos  <= w_pos_dec;
            lights <= C_LIGHT1 << w_pos_dec;
          end
        end
        HOLD: begin
          // freeze only matters on the last blank cycle
          if (w_hold_done) begin
            if (freeze) begin
              r_state <= DONE;
            end else begin
              r_state <= PLAY;
              r_pos   <= C_CENTRE;
              lights  <= C_LIGHT1 << C_CENTRE;
              playing <= 1'b1;
            end
          end
        end
        DONE: begin
          lights  <= '0;
          playing <= 1'b0;
        end
        default: begin
          r_state <= PLAY;
          r_pos   <= C_CENTRE;
          lights  <= C_LIGHT1 << C_CENTRE;
          playing <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tow_playfield.sv
`default_nettype none
// ============================================================================
// Module      : tb_tow_playfield
// Description : Directed testbench for tow_playfield (9 lights, 4-cycle hold).
//               Inputs change on the falling edge; outputs are checked on the
//               following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tow_playfield;

  localparam int N = 9;
  localparam int H = 4;

  logic         clk;
  logic         Reset;
  logic         L_press;
  logic         R_press;
  logic         freeze;
  logic [N-1:0] lights;
  logic         left_win;
  logic         right_win;
  logic         playing;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [N-1:0] CTR = 9'b000010000;

  tow_playfield #(
    .NUM_LIGHTS  (N),
    .HOLD_CYCLES (H)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .L_press   (L_press),
    .R_press   (R_press),
    .freeze    (freeze),
    .lights    (lights),
    .left_win  (left_win),
    .right_win (right_win),
    .playing   (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare packed {lights, left_win, right_win, playing}
  task automatic check(input string tag, input logic [N+2:0] got, input logic [N+2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got lights=%b lw=%b rw=%b play=%b, want lights=%b lw=%b rw=%b play=%b",
               tag, got[N+2:3], got[2], got[1], got[0], exp[N+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] l, input logic lw,
                            input logic rw, input logic p);
    check(tag, {lights, left_win, right_win, playing}, {l, lw, rw, p});
  endtask

  // Apply presses for one clock edge; outputs settle before return
  task automatic tick(input logic l, input logic r);
    L_press = l;
    R_press = r;
    @(negedge clk);
    L_press = 1'b0;
    R_press = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; L_press = 1'b0; R_press = 1'b0; freeze = 1'b0;
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    expect_out("reset", CTR, 0, 0, 1);

    // 1: idle at centre
    for (int i = 0; i < 5; i++) begin
      tick(0, 0);
      expect_out("idle", CTR, 0, 0, 1);
    end

    // 2: walk left, win, hold, restart
    tick(1, 0); expect_out("L1", 9'b000100000, 0, 0, 1);
    tick(1, 0); expect_out("L2", 9'b001000000, 0, 0, 1);
    tick(1, 0); expect_out("L3", 9'b010000000, 0, 0, 1);
    tick(1, 0); expect_out("L4", 9'b100000000, 0, 0, 1);
    tick(1, 0); expect_out("lwin", '0, 1, 0, 0);
    for (int i = 0; i < H - 1; i++) begin
      tick(0, 0); expect_out("lhold", '0, 0, 0, 0);
    end
    tick(0, 0); expect_out("lrestart", CTR, 0, 0, 1);

    // 3: simultaneous presses cancel at centre and at the right end
    tick(1, 1); expect_out("both_ctr", CTR, 0, 0, 1);
    tick(0, 1); expect_out("R1", 9'b000001000, 0, 0, 1);
    tick(0, 1); expect_out("R2", 9'b000000100, 0, 0, 1);
    tick(0, 1); expect_out("R3", 9'b000000010, 0, 0, 1);
    tick(0, 1); expect_out("R4", 9'b000000001, 0, 0, 1);
    tick(1, 1); expect_out("both_end", 9'b000000001, 0, 0, 1);

    // 4: right win, presses ignored during hold, first PLAY press honoured
    tick(0, 1); expect_out("rwin", '0, 0, 1, 0);
    tick(1, 0); expect_out("hold_L", '0, 0, 0, 0);
    tick(0, 1); expect_out("hold_R", '0, 0, 0, 0);
    tick(1, 1); expect_out("hold_LR", '0, 0, 0, 0);
    tick(1, 0); expect_out("rrestart", CTR, 0, 0, 1);
    tick(1, 0); expect_out("first_press", 9'b000100000, 0, 0, 1);
    tick(0, 1); expect_out("back_ctr", CTR, 0, 0, 1);

    // 5: frozen game parks blank after the next win
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) tick(0, 1);
    expect_out("frz_end", 9'b000000001, 0, 0, 1);
    tick(0, 1); expect_out("frz_rwin", '0, 0, 1, 0);
    for (int i = 0; i < H - 1; i++) begin
      tick(0, 0); expect_out("frz_hold", '0, 0, 0, 0);
    end
    tick(0, 0); expect_out("done", '0, 0, 0, 0);
    freeze = 1'b0;
    tick(1, 0); expect_out("done_L", '0, 0, 0, 0);
    tick(0, 1); expect_out("done_R", '0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0);
    expect_out("done_stay", '0, 0, 0, 0);
    Reset = 1'b1;
    tick(0, 0); expect_out("done_rst", CTR, 0, 0, 1);
    Reset = 1'b0;
    tick(0, 1); expect_out("after_rst", 9'b000001000, 0, 0, 1);
    tick(1, 0); expect_out("after_rst2", CTR, 0, 0, 1);

    // 6: reset during the second hold cycle
    for (int i = 0; i < 4; i++) tick(1, 0);
    tick(1, 0); expect_out("h_lwin", '0, 1, 0, 0);
    tick(0, 0); expect_out("h_cyc2", '0, 0, 0, 0);
    Reset = 1'b1;
    tick(1, 0); expect_out("h_rst", CTR, 0, 0, 1);
    Reset = 1'b0;
    for (int i = 0; i < H + 1; i++) begin
      tick(0, 0); expect_out("h_post", CTR, 0, 0, 1);
    end
    tick(1, 0); expect_out("h_play", 9'b000100000, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
